// File: rtl/tail_light_seq.sv
// Purpose: sequential tail-light controller (left/right sweep, hazard, brake override, step prescaler).
// Latency: lights is registered; an input change shows on lights exactly one Clk edge later.
// Backpressure: none; level-sensitive inputs are sampled every edge and lamps are driven continuously.
module tail_light_seq #(
    parameter int N_LAMPS = 3,
    parameter int DIV     = 1,
    parameter int CW      = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   left,
    input  logic                   right,
    input  logic                   hazard,
    input  logic                   brake,
    output logic [2*N_LAMPS-1:0]   lights
);

    localparam int SW = $clog2(N_LAMPS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } mode_t;

    mode_t                  mode, mode_n, req;
    logic [SW-1:0]          step, step_n, last_step;
    logic [CW-1:0]          pre, pre_n;
    logic                   brake_q, brake_n;
    logic [2*N_LAMPS-1:0]   lights_n;

    // State register: mode, sequence position, prescaler, brake sample and lamp outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mode    <= IDLE;
            step    <= '0;
            pre     <= '0;
            brake_q <= 1'b0;
            lights  <= '0;
        end else begin
            mode    <= mode_n;
            step    <= step_n;
            pre     <= pre_n;
            brake_q <= brake_n;
            lights  <= lights_n;
        end
    end

    // Next-state: requested mode by priority, restart on mode change, otherwise prescaled stepping.
    always_comb begin
        req       = IDLE;
        mode_n    = mode;
        step_n    = step;
        pre_n     = pre;
        brake_n   = brake;
        last_step = (mode == HAZ) ? SW'(1) : SW'(N_LAMPS);

        if (hazard || (left && right)) begin
            req = HAZ;
        end else if (left) begin
            req = LEFT;
        end else if (right) begin
            req = RIGHT;
        end

        if (req != mode) begin
            // A new mode always starts its pattern from scratch; no prescaler carry.
            mode_n = req;
            step_n = '0;
            pre_n  = '0;
        end else if (mode == IDLE) begin
            step_n = '0;
            pre_n  = '0;
        end else if (pre == CW'(DIV - 1)) begin
            pre_n  = '0;
            step_n = (step == last_step) ? '0 : step + SW'(1);
        end else begin
            pre_n  = pre + CW'(1);
        end
    end

    // Lamp pattern derived from next-state values so the output register adds only one edge of delay.
    always_comb begin
        lights_n = '0;
        case (mode_n)
            IDLE: begin
                if (brake_n) begin
                    lights_n = '1;
                end
            end
            LEFT: begin
                // Left side: bit N_LAMPS innermost, growing outward with step.
                if (int'(step_n) < N_LAMPS) begin
                    for (int i = 0; i < N_LAMPS; i++) begin
                        if (i <= int'(step_n)) begin
                            lights_n[N_LAMPS + i] = 1'b1;
                        end
                    end
                end
                if (brake_n) begin
                    lights_n[N_LAMPS-1:0] = '1;
                end
            end
            RIGHT: begin
                // Right side: bit N_LAMPS-1 innermost, growing toward bit 0 with step.
                if (int'(step_n) < N_LAMPS) begin
                    for (int i = 0; i < N_LAMPS; i++) begin
                        if (i <= int'(step_n)) begin
                            lights_n[N_LAMPS - 1 - i] = 1'b1;
                        end
                    end
                end
                if (brake_n) begin
                    lights_n[2*N_LAMPS-1:N_LAMPS] = '1;
                end
            end
            HAZ: begin
                // Brake has no effect while hazards flash.
                if (step_n == '0) begin
                    lights_n = '1;
                end
            end
            default: lights_n = '0;
        endcase
    end

endmodule
